// File: rtl/uart_tx_word_module_pkg.sv
// uart_tx_word_module_pkg: shared UART timing helpers and word framer state encoding
package uart_tx_word_module_pkg;
    typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} tx_word_state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int bit_cycles(input int clk_fre, input int bps);
        return clk_fre * 1000000 / bps;
    endfunction
endpackage

// File: rtl/uart_tx_word_module.sv
// uart_tx_word_module: frames one word into bytes for uart_tx_module and enforces an idle gap after each frame
module uart_tx_word_module
    import uart_tx_word_module_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int BPS        = 115200,
    parameter int IDLE_CYCLE = 20,
    parameter int REG_WIDTH  = 32,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] word_data,
    input  logic                 word_valid,
    output logic                 word_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int NBYTES     = (REG_WIDTH + 7) / 8;
    localparam int DW         = NBYTES * 8;
    localparam int GAP_CYCLES = IDLE_CYCLE * bit_cycles(CLK_FRE, BPS);
    localparam int BW         = NBYTES > 1 ? clog2(NBYTES) : 1;
    localparam int GW         = GAP_CYCLES > 0 ? clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    tx_word_state_t state, state_nxt;
    logic [DW-1:0]  shreg, ext, shifted;
    logic [BW-1:0]  byte_cnt;
    logic [GW-1:0]  gap_cnt;
    logic           in_drain, accept, xfer, last;

    assign word_ready    = state == IDLE;
    assign tx_data_valid = state == SEND;
    assign busy          = state != IDLE;

    always_comb begin
        ext     = DW'(word_data);
        shifted = (MSB_FIRST != 0) ? shreg << 8 : shreg >> 8;
        accept  = word_valid && word_ready;
        xfer    = tx_data_valid && tx_data_ready;
        last    = byte_cnt == LAST_BYTE;
    end

    // in_drain masks the DRAIN entry cycle, when downstream may still show the ready of the last transfer
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE:  state_nxt = word_valid ? SEND : IDLE;
            SEND:  state_nxt = (tx_data_ready && last) ? DRAIN : SEND;
            DRAIN: if (in_drain && tx_data_ready) begin
                state_nxt  = (IDLE_CYCLE == 0) ? IDLE : GAP;
                frame_done = IDLE_CYCLE == 0;
            end
            GAP:   if (gap_cnt == GAP_LAST) begin
                state_nxt  = IDLE;
                frame_done = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            tx_data  <= 8'h00;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            in_drain <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_drain <= state == DRAIN;
            gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (accept) begin
                shreg    <= ext;
                tx_data  <= (MSB_FIRST != 0) ? ext[DW-1 -: 8] : ext[7:0];
                byte_cnt <= '0;
            end else if (xfer && !last) begin
                shreg    <= shifted;
                tx_data  <= (MSB_FIRST != 0) ? shifted[DW-1 -: 8] : shifted[7:0];
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_word_module.sv
// tb_uart_tx_word_module: directed vector bench over three framer configurations with a ready-dropping tx model
module tb_uart_tx_word_module;
    typedef struct {
        int          i;
        logic [31:0] w;
        logic [31:0] e;
        int          n;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wd [3];
    logic        wv [3];
    logic        wr [3];
    logic [7:0]  td [3];
    logic        tv [3];
    logic        tr [3];
    logic        busy [3];
    logic        done [3];
    logic        hold [3];
    int          rc [3] = '{0, 0, 0};

    int acc_cyc [3] = '{0, 0, 0};
    int acc_n [3] = '{0, 0, 0};
    int val_rise [3] = '{0, 0, 0};
    int rdy_rise [3] = '{0, 0, 0};
    int done_cyc [3] = '{0, 0, 0};
    int done_n [3] = '{0, 0, 0};
    int bn [3] = '{0, 0, 0};
    int fb [3] = '{0, 0, 0};
    int ev_err [3] = '{0, 0, 0};
    logic in_frame [3] = '{1'b0, 1'b0, 1'b0};
    logic pv [3] = '{1'b0, 1'b0, 1'b0};
    logic pr [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0] bl [3][64];
    int cyc = 0;
    int cmp = 0;
    int fail = 0;
    vec_t tbl [7];

    always #5 clk = ~clk;

    uart_tx_word_module #(.CLK_FRE(1), .BPS(250000), .IDLE_CYCLE(2), .REG_WIDTH(32), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .word_data(wd[0]), .word_valid(wv[0]), .word_ready(wr[0]),
        .tx_data(td[0]), .tx_data_valid(tv[0]), .tx_data_ready(tr[0]), .busy(busy[0]), .frame_done(done[0]));
    uart_tx_word_module #(.CLK_FRE(1), .BPS(250000), .IDLE_CYCLE(2), .REG_WIDTH(12), .MSB_FIRST(0)) dut_lsb12 (
        .clk(clk), .rst(rst), .word_data(wd[1][11:0]), .word_valid(wv[1]), .word_ready(wr[1]),
        .tx_data(td[1]), .tx_data_valid(tv[1]), .tx_data_ready(tr[1]), .busy(busy[1]), .frame_done(done[1]));
    uart_tx_word_module #(.CLK_FRE(1), .BPS(250000), .IDLE_CYCLE(0), .REG_WIDTH(32), .MSB_FIRST(1)) dut_nogap (
        .clk(clk), .rst(rst), .word_data(wd[2]), .word_valid(wv[2]), .word_ready(wr[2]),
        .tx_data(td[2]), .tx_data_valid(tv[2]), .tx_data_ready(tr[2]), .busy(busy[2]), .frame_done(done[2]));

    // downstream uart_tx model: ready idles high and drops for 40 cycles after each accepted byte
    always_comb for (int i = 0; i < 3; i++) tr[i] = (rc[i] == 0) && !hold[i];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) rc[i] <= (tv[i] && tr[i]) ? 40 : (rc[i] != 0 ? rc[i] - 1 : 0);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                in_frame[i] = 1'b0;
                fb[i] = 0;
            end else begin
                if (in_frame[i] && !busy[i]) ev_err[i]++;
                if (in_frame[i] && fb[i] == (i == 1 ? 2 : 4) && tv[i]) ev_err[i]++;
                if (done[i] && wr[i]) ev_err[i]++;
                if (tv[i] && tr[i] && bn[i] < 64) begin
                    bl[i][bn[i]] = td[i];
                    bn[i]++;
                    fb[i]++;
                end
                if (tv[i] && !pv[i]) val_rise[i] = cyc;
                if (tr[i] && !pr[i]) rdy_rise[i] = cyc;
                if (done[i]) begin
                    done_cyc[i] = cyc;
                    done_n[i]++;
                    in_frame[i] = 1'b0;
                end
                if (wv[i] && wr[i]) begin
                    acc_cyc[i] = cyc;
                    acc_n[i]++;
                    in_frame[i] = 1'b1;
                    fb[i] = 0;
                end
            end
            pv[i] = tv[i];
            pr[i] = tr[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int i, input logic [31:0] w);
        int k;
        k = 0;
        wd[i] = w;
        wv[i] = 1'b1;
        while (!wr[i] && k < 5000) begin
            tick();
            k++;
        end
        chk("accept_seen", 32'(k < 5000), 1);
        tick();
        wv[i] = 1'b0;
        wd[i] = ~w;
    endtask

    task automatic finish_vec(input int i, input int b0, input int d0, input logic [31:0] e, input int n);
        int k;
        k = 0;
        while (done_n[i] <= d0 && k < 5000) begin
            tick();
            k++;
        end
        chk("frame_done_seen", 32'(k < 5000), 1);
        chk("ready_after_done", 32'(wr[i]), 1);
        chk("valid_latency", 32'(val_rise[i] - acc_cyc[i]), 1);
        chk("gap_cycles", 32'(done_cyc[i] - rdy_rise[i]), (i == 2) ? 0 : 8);
        chk("byte_count", 32'(bn[i] - b0), 32'(n));
        for (int j = 0; j < n; j++) chk("byte_value", 32'(bl[i][b0 + j]), 32'(e[8 * (n - 1 - j) +: 8]));
    endtask

    task automatic run_vec(input int i, input logic [31:0] w, input logic [31:0] e, input int n);
        int b0, d0;
        b0 = bn[i];
        d0 = done_n[i];
        send(i, w);
        finish_vec(i, b0, d0, e, n);
    endtask

    initial begin
        int b0, d0, a0, k, stable_err;
        logic [31:0] b2b;
        for (int i = 0; i < 3; i++) begin
            wd[i] = '0;
            wv[i] = 1'b0;
            hold[i] = 1'b0;
        end
        tbl[0] = '{0, 32'hA1B2C3D4, 32'hA1B2C3D4, 4};
        tbl[1] = '{0, 32'h80000001, 32'h80000001, 4};
        tbl[2] = '{1, 32'h00000ABC, 32'h0000BC0A, 2};
        tbl[3] = '{1, 32'h00000123, 32'h00002301, 2};
        tbl[4] = '{1, 32'h00000FFF, 32'h0000FF0F, 2};
        tbl[5] = '{2, 32'hDEADBEEF, 32'hDEADBEEF, 4};
        tbl[6] = '{2, 32'h0102A5FF, 32'h0102A5FF, 4};
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_word_ready", 32'(wr[i]), 1);
            chk("rst_tx_data", 32'(td[i]), 0);
            chk("rst_tx_valid", 32'(tv[i]), 0);
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_frame_done", 32'(done[i]), 0);
        end
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) run_vec(tbl[v].i, tbl[v].w, tbl[v].e, tbl[v].n);

        // back-to-back: word_valid held across two frames
        b0 = bn[0];
        d0 = done_n[0];
        a0 = acc_n[0];
        wd[0] = 32'h11223344;
        wv[0] = 1'b1;
        k = 0;
        while (acc_n[0] == a0 && k < 5000) begin
            tick();
            k++;
        end
        wd[0] = 32'h55667788;
        while (acc_n[0] < a0 + 2 && k < 5000) begin
            tick();
            k++;
        end
        wv[0] = 1'b0;
        chk("b2b_accepts", 32'(acc_n[0] - a0), 2);
        chk("b2b_accept_after_done", 32'(acc_cyc[0] - done_cyc[0]), 1);
        finish_vec(0, b0 + 4, d0 + 1, 32'h55667788, 4);
        b2b = 32'h11223344;
        for (int j = 0; j < 4; j++) chk("b2b_first_byte", 32'(bl[0][b0 + j]), 32'(b2b[8 * (3 - j) +: 8]));

        // backpressure: ready withheld for 100 cycles with the first byte pending
        b0 = bn[0];
        d0 = done_n[0];
        hold[0] = 1'b1;
        send(0, 32'hCAFEF00D);
        stable_err = 0;
        repeat (100) begin
            if (td[0] !== 8'hCA || tv[0] !== 1'b1) stable_err++;
            tick();
        end
        chk("backpressure_stable", 32'(stable_err), 0);
        hold[0] = 1'b0;
        finish_vec(0, b0, d0, 32'hCAFEF00D, 4);

        // reset after the second byte of a frame
        b0 = bn[0];
        send(0, 32'h12345678);
        k = 0;
        while (bn[0] < b0 + 2 && k < 5000) begin
            tick();
            k++;
        end
        rst = 1'b1;
        tick();
        chk("midrst_tx_valid", 32'(tv[0]), 0);
        chk("midrst_word_ready", 32'(wr[0]), 1);
        chk("midrst_busy", 32'(busy[0]), 0);
        chk("midrst_tx_data", 32'(td[0]), 0);
        rst = 1'b0;
        tick();
        chk("midrst_bytes_before", 32'(bn[0] - b0), 2);
        run_vec(0, 32'h0000FFFF, 32'h0000FFFF, 4);

        for (int i = 0; i < 3; i++) chk("frame_events", 32'(ev_err[i]), 0);
        $display("== %0d vectors applied, %0d miscompares ==", cmp, fail);
        $finish;
    end
endmodule
